ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000, clk cycles ps2_clk is held low before start (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, max clk cycles between device falling edges (or from clock release) before abort.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port tx_data  input  8  command byte to send to the keyboard.
REQ-006 SHALL have port tx_start  input  1  request strobe, sampled each clk.
REQ-007 SHALL have port ps2_clk_in  input  1  raw PS/2 clock line level (asynchronous).
REQ-008 SHALL have port ps2_data_in  input  1  raw PS/2 data line level (asynchronous).
REQ-009 SHALL have port ps2_clk_oe  output  1  1 = pull PS/2 clock low, 0 = release (open drain).
REQ-010 SHALL have port ps2_data_oe  output  1  1 = pull PS/2 data low, 0 = release.
REQ-011 SHALL have port busy  output  1  high from accepted start until return to IDLE.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse, frame acknowledged by device.
REQ-013 SHALL have port tx_err  output  1  one-cycle pulse, missing ack or timeout.

Function
REQ-014 SHALL pass ps2_clk_in and ps2_data_in through two-flop synchronizers; all decisions use synchronized values; a device falling edge = synchronized clock 1 then 0 on consecutive cycles.
REQ-015 SHALL implement states IDLE, INHIBIT, START, BITS, ACK, WAIT_IDLE.
REQ-016 IDLE: outputs released, busy 0; tx_start=1 latches tx_data, computes odd parity (parity bit = ~^tx_data), clears bit counter and timer, goes to INHIBIT next cycle; busy rises the same edge.
REQ-017 tx_start while busy SHALL be ignored; latched byte SHALL not change mid-frame.
REQ-018 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe=1 asserted in the last cycle of INHIBIT; then START.
REQ-019 START: ps2_clk_oe=0, ps2_data_oe=1 (start bit 0); timer restarted; on first device falling edge drive data bit 0 and enter BITS.
REQ-020 BITS: on each subsequent falling edge present next bit: data bits 1..7 (LSB first), then parity, then stop; a bit value 1 SHALL be ps2_data_oe=0, value 0 ps2_data_oe=1; stop bit SHALL release data.
REQ-021 After the stop bit is presented, the next falling edge SHALL move to ACK; 11 falling edges total per frame counting the first in START.
REQ-022 ACK: sample synchronized data on the cycle of the falling edge detection entering ACK; 0 = ack ok, 1 = ack fail; then WAIT_IDLE.
REQ-023 WAIT_IDLE: wait until synchronized clock and data both 1, then IDLE with tx_done (ack ok) or tx_err (ack fail) pulsed exactly one cycle on that transition.
REQ-024 Timer SHALL reset on every falling edge and state entry; reaching TIMEOUT_CYCLES in START, BITS, ACK or WAIT_IDLE SHALL release both lines, pulse tx_err one cycle, go to IDLE.
REQ-025 tx_done and tx_err SHALL never be high in the same cycle; busy SHALL be 0 in the cycle either pulses.
REQ-026 Counters SHALL be wide enough for the larger of INHIBIT_CYCLES and TIMEOUT_CYCLES with no wrap-around.

Reset
REQ-027 rst=1 at a clk edge SHALL force IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_done=0, tx_err=0, counters and synchronizers to idle (1) values, regardless of state.
REQ-028 rst asserted mid-frame SHALL release both lines the following cycle with no tx_done/tx_err pulse; tx_start coincident with rst SHALL be ignored.

Verification
REQ-029 tx_data=0xED, tx_start pulse, device model clocks 11 edges and acks low -> clk held low 10000 cycles, data bits 1,0,1,1,0,1,1,1, parity 1, stop released, tx_done one pulse, busy low after.
REQ-030 tx_data=0x00 -> parity bit 1 on the line; tx_data=0x01 -> parity bit 0.
REQ-031 Device leaves data high at ack -> tx_err one pulse, tx_done stays 0.
REQ-032 Device never clocks after release -> tx_err pulse exactly TIMEOUT_CYCLES after START entry, both oe 0.
REQ-033 Second tx_start=1 with tx_data=0x55 during BITS of 0xF4 frame -> line carries 0xF4 only, one tx_done.
REQ-034 rst=1 during BITS -> next cycle both oe 0, busy 0, no pulses; new tx_start afterward sends full frame.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx_if
// Description : Command handshake between a PS/2 host transmitter and its user.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data,
        output tx_start,
        input  busy,
        input  tx_done,
        input  tx_err
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output busy,
        output tx_done,
        output tx_err
    );
endinterface
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device frame transmitter (inhibit, start, 8 data,
//               odd parity, stop, ack) driving open-drain clock/data enables.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  wire logic      clk,
    input  wire logic      rst,
    ps2_host_tx_if.slave   tx_if,
    input  wire logic      ps2_clk_in,
    input  wire logic      ps2_data_in,
    output logic           ps2_clk_oe,
    output logic           ps2_data_oe
);

    localparam int c_CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_INHIBIT_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
    localparam logic [3:0]         c_STOP_IDX     = 4'd9;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_INHIBIT   = 3'd1;
    localparam logic [2:0] c_START     = 3'd2;
    localparam logic [2:0] c_BITS      = 3'd3;
    localparam logic [2:0] c_ACK       = 3'd4;
    localparam logic [2:0] c_WAIT_IDLE = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [1:0]         r_clk_sync;
    logic [1:0]         r_data_sync;
    logic               r_clk_q;
    logic [c_CNT_W-1:0] r_timer;
    logic [3:0]         r_bitcnt;
    logic [9:0]         r_frame;
    logic               r_ack_fail;
    logic               r_tx_done;
    logic               r_tx_err;
    logic               w_clk_s;
    logic               w_data_s;
    logic               w_fall;
    logic               w_timeout;
    logic               w_done_set;
    logic               w_err_set;

    assign w_clk_s   = r_clk_sync[1];
    assign w_data_s  = r_data_sync[1];
    assign w_fall    = r_clk_q & ~w_clk_s;
    assign w_timeout = (r_timer == c_TIMEOUT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a device edge or line release wins over a coincident timeout
    always_comb begin
        w_state_nxt = r_state;
        w_done_set  = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (tx_if.tx_start) w_state_nxt = c_INHIBIT;
            end
            c_INHIBIT: begin
                if (r_timer == c_INHIBIT_LAST) w_state_nxt = c_START;
            end
            c_START: begin
                if (w_fall) begin
                    w_state_nxt = c_BITS;
                end else if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                    w_err_set   = 1'b1;
                end
            end
            c_BITS: begin
                if (w_fall) begin
                    if (r_bitcnt == c_STOP_IDX) w_state_nxt = c_ACK;
                end else if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                    w_err_set   = 1'b1;
                end
            end
            c_ACK: begin
                if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                    w_err_set   = 1'b1;
                end else begin
                    w_state_nxt = c_WAIT_IDLE;
                end
            end
            c_WAIT_IDLE: begin
                if (w_clk_s && w_data_s) begin
                    w_state_nxt = c_IDLE;
                    w_done_set  = ~r_ack_fail;
                    w_err_set   = r_ack_fail;
                end else if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                    w_err_set   = 1'b1;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (r_state)
            c_INHIBIT: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = (r_timer == c_INHIBIT_LAST);
            end
            c_START: ps2_data_oe = 1'b1;
            c_BITS:  ps2_data_oe = ~r_frame[r_bitcnt];
            default: begin
                ps2_clk_oe  = 1'b0;
                ps2_data_oe = 1'b0;
            end
        endcase
    end

    assign tx_if.busy    = (r_state != c_IDLE);
    assign tx_if.tx_done = r_tx_done;
    assign tx_if.tx_err  = r_tx_err;

    // Synchronizers, timer, bit counter and frame shift data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_q     <= 1'b1;
            r_timer     <= '0;
            r_bitcnt    <= 4'd0;
            r_frame     <= 10'h3FF;
            r_ack_fail  <= 1'b0;
            r_tx_done   <= 1'b0;
            r_tx_err    <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
            r_data_sync <= {r_data_sync[0], ps2_data_in};
            r_clk_q     <= w_clk_s;
            r_tx_done   <= w_done_set;
            r_tx_err    <= w_err_set;

            // Our own clock pull-down during INHIBIT looks like an edge; ignore it there
            if ((w_state_nxt != r_state) || (w_fall && (r_state != c_INHIBIT))) begin
                r_timer <= '0;
            end else if (r_state != c_IDLE) begin
                r_timer <= r_timer + c_CNT_ONE;
            end

            if ((r_state == c_IDLE) && tx_if.tx_start) begin
                r_frame  <= {1'b1, ~^tx_if.tx_data, tx_if.tx_data};
                r_bitcnt <= 4'd0;
            end

            if ((r_state == c_BITS) && w_fall) begin
                if (r_bitcnt == c_STOP_IDX) begin
                    r_ack_fail <= w_data_s;
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Directed bench for ps2_host_tx with a PS/2 device line model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int c_INHIBIT = 40;
    localparam int c_TIMEOUT = 400;
    localparam int c_HALF    = 8;

    logic clk;
    logic rst;
    logic dev_clk;
    logic dev_data;
    logic ps2_clk_oe;
    logic ps2_data_oe;
    logic clk_line;
    logic data_line;

    int n_checks;
    int n_errors;

    logic q_bits[$];
    logic q_res[$];

    ps2_host_tx_if tif ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (c_INHIBIT),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_if       (tif),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    // Open-drain wired-AND of host and device
    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Request a frame and measure the inhibit phase; returns at the first START cycle
    task automatic start_tx(input logic [7:0] data, input logic ack_low, input bit push_bits);
        int cnt;
        int dcnt;
        logic last;
        @(negedge clk);
        tif.tx_data  = data;
        tif.tx_start = 1'b1;
        if (push_bits) begin
            q_bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) q_bits.push_back(data[i]);
            q_bits.push_back(~^data);
            q_bits.push_back(1'b1);
        end
        q_res.push_back(ack_low);
        @(negedge clk);
        tif.tx_start = 1'b0;
        check("busy_rise", tif.busy, 1);
        cnt  = 0;
        dcnt = 0;
        last = 1'b0;
        while (ps2_clk_oe === 1'b1 && cnt < c_INHIBIT + 20) begin
            cnt++;
            dcnt += int'(ps2_data_oe);
            last = ps2_data_oe;
            @(negedge clk);
        end
        check("inhibit_len", cnt, c_INHIBIT);
        check("inhibit_data_oe_cycles", dcnt, 1);
        check("inhibit_data_oe_last", last, 1);
    endtask

    task automatic wait_result();
        int n;
        logic exp_ok;
        n = 0;
        while (!(tif.tx_done || tif.tx_err) && n < 200) begin
            @(negedge clk);
            n++;
        end
        exp_ok = 1'bx;
        if (q_res.size() != 0) exp_ok = q_res.pop_front();
        check("tx_done", tif.tx_done, exp_ok);
        check("tx_err", tif.tx_err, !exp_ok);
        check("busy_at_pulse", tif.busy, 0);
        check("oe_at_pulse", {ps2_clk_oe, ps2_data_oe}, 0);
        @(negedge clk);
        check("pulse_one_cycle", {tif.tx_done, tif.tx_err}, 0);
    endtask

    // Device model: clocks 11 falling edges, checks each presented bit before the edge
    task automatic run_frame(input logic [7:0] data, input logic ack_low,
                             input int poke_edge, input int rst_edge);
        logic exp_bit;
        int bad;
        start_tx(data, ack_low, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            repeat (c_HALF) @(negedge clk);
            exp_bit = 1'bx;
            if (q_bits.size() != 0) exp_bit = q_bits.pop_front();
            check($sformatf("bit%0d_of_%02h", k, data), data_line, exp_bit);
            if (k == 11) dev_data = !ack_low;
            @(negedge clk);
            dev_clk = 1'b0;
            if (k == poke_edge) begin
                tif.tx_data  = 8'h55;
                tif.tx_start = 1'b1;
                @(negedge clk);
                tif.tx_start = 1'b0;
            end
            if (k == rst_edge) begin
                rst          = 1'b1;
                tif.tx_start = 1'b1;
                @(negedge clk);
                rst          = 1'b0;
                tif.tx_start = 1'b0;
                check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
                check("rst_busy", tif.busy, 0);
                bad = 0;
                repeat (30) begin
                    @(negedge clk);
                    if (tif.tx_done || tif.tx_err || tif.busy || ps2_clk_oe) bad++;
                end
                check("rst_quiet", bad, 0);
                dev_clk  = 1'b1;
                dev_data = 1'b1;
                q_bits.delete();
                if (q_res.size() != 0) void'(q_res.pop_front());
                return;
            end
            repeat (c_HALF) @(negedge clk);
            if (k < 11) dev_clk = 1'b1;
        end
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        wait_result();
    endtask

    initial begin
        int cnt;
        int bad;
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        dev_clk      = 1'b1;
        dev_data     = 1'b1;
        tif.tx_data  = 8'h00;
        tif.tx_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("reset_busy", tif.busy, 0);
        check("reset_pulses", {tif.tx_done, tif.tx_err}, 0);

        run_frame(8'hED, 1'b1, 0, 0);
        run_frame(8'h00, 1'b1, 0, 0);
        run_frame(8'h01, 1'b1, 0, 0);
        run_frame(8'hA5, 1'b0, 0, 0);

        // Device never clocks: error exactly TIMEOUT cycles after START entry
        start_tx(8'h3C, 1'b0, 1'b0);
        cnt = 0;
        while (!tif.tx_err && cnt < c_TIMEOUT + 50) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_cycles", cnt, c_TIMEOUT);
        wait_result();

        // Request while busy must not disturb or queue behind the current frame
        run_frame(8'hF4, 1'b1, 4, 0);
        bad = 0;
        repeat (3 * c_INHIBIT) begin
            @(negedge clk);
            if (tif.busy || ps2_clk_oe || tif.tx_done || tif.tx_err) bad++;
        end
        check("ignored_start_quiet", bad, 0);

        run_frame(8'h12, 1'b1, 0, 5);
        run_frame(8'hED, 1'b1, 0, 0);

        check("bits_queue_empty", q_bits.size(), 0);
        check("res_queue_empty", q_res.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
